// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
// Revision: 1.0
`default_nettype none

package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PC_STEP   = 4;
    localparam int FE_ADDR_W = 32;

    typedef struct packed {
        logic [31:0]          instr;
        logic [FE_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch FIFO; flush has priority over push.
// Revision: 1.0
`default_nettype none

module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, req/gnt/rvalid memory requester and prefetch buffer.
// Revision: 1.0
`default_nettype none

module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                MAX_OUT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int DW    = 32 + ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  r_disc;

    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [DW-1:0]     w_head;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic [OUT_W-1:0]  w_rv;
    logic [OUT_W-1:0]  w_gn;
    logic [OUT_W-1:0]  w_redir_disc;
    logic [ADDR_W-1:0] w_redir_pc;

    // Space is reserved for every in-flight word, so the FIFO never overflows.
    assign mem_req = (r_state == RUN)
                  && ((32'(w_count) + 32'(r_out)) < 32'(FIFO_DEPTH))
                  && (32'(r_out) < 32'(MAX_OUT))
                  && !redirect_valid;
    assign mem_addr     = r_fetch_pc;
    assign w_grant      = mem_req && mem_gnt;
    assign w_rv         = OUT_W'(mem_rvalid);
    assign w_gn         = OUT_W'(w_grant);
    assign w_redir_disc = r_out - w_rv;
    assign w_redir_pc   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_push       = mem_rvalid && (r_disc == '0) && !redirect_valid;
    assign w_pop        = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !w_empty;
    assign instr       = w_head[DW-1:ADDR_W];
    assign instr_pc    = w_head[ADDR_W-1:0];

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   ({mem_rdata, r_resp_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_disc     <= '0;
        end else if (redirect_valid) begin
            // Every word still owed by memory belongs to the old stream.
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_out      <= w_redir_disc;
            r_disc     <= w_redir_disc;
            r_state    <= (w_redir_disc != '0) ? DRAIN : RUN;
        end else begin
            r_out <= r_out + w_gn - w_rv;
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + ADDR_W'(PC_STEP);
            end
            if (mem_rvalid && (r_disc != '0)) begin
                r_disc <= r_disc - OUT_W'(1);
            end
            case (r_state)
                IDLE:    r_state <= RUN;
                DRAIN:   if ((r_disc == '0) || ((r_disc == OUT_W'(1)) && mem_rvalid)) r_state <= RUN;
                default: r_state <= r_state;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_full;

endmodule

`default_nettype wire
